// File: rtl/bus_pkg.sv
// bus_pkg: shared constants for the bus fabric and its source FIFOs.
// Packets carry the destination ID in their top ID_W bits.
package bus_pkg;

   localparam int PCKG_SZ = 16;
   localparam int ID_W = 8;
   localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;
   localparam int DROP_W = 8;

   function automatic logic [ID_W-1:0] pkt_id(
      input logic [PCKG_SZ-1:0] p
   );
      return p[PCKG_SZ-1 -: ID_W];
   endfunction

endpackage

// File: rtl/bus_src_fifo.sv
// bus_src_fifo: agent-side source FIFO for one bus driver slot.
// First-word fall-through circular buffer with sticky error flags.
module bus_src_fifo
   import bus_pkg::*;
#(
   parameter int pckg_sz = PCKG_SZ,
   parameter int depth = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [pckg_sz-1:0]       D_push,
   input  logic                     pop,
   output logic [pckg_sz-1:0]       D_pop,
   output logic                     pndng,
   output logic                     full,
   output logic [$clog2(depth):0]   count,
   output logic                     overflow,
   output logic                     underflow,
   output logic [DROP_W-1:0]        drop_cnt,
   input  logic                     clr_flags
);

   localparam int AW = $clog2(depth);
   localparam int CW = AW + 1;

   logic [pckg_sz-1:0] mem [depth];
   logic [AW-1:0]      rd_ptr;
   logic [AW-1:0]      wr_ptr;
   logic               is_empty;
   logic               is_full;
   logic               do_push;
   logic               do_pop;
   logic               ovf_ev;
   logic               unf_ev;

   assign is_empty = (count == '0);
   assign is_full  = (count == CW'(depth));
   assign do_pop   = pop && !is_empty;
   // a pop on a full FIFO frees the slot the push needs
   assign do_push  = push && (!is_full || do_pop);
   assign ovf_ev   = push && is_full && !pop;
   assign unf_ev   = pop && is_empty;

   assign pndng = !is_empty;
   assign full  = is_full;
   assign D_pop = is_empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= D_push;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // a same-cycle error event wins over clr_flags
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
         drop_cnt  <= '0;
      end else if (clr_flags) begin
         overflow  <= ovf_ev;
         underflow <= unf_ev;
         drop_cnt  <= ovf_ev ? DROP_W'(1) : '0;
      end else begin
         if (ovf_ev) overflow <= 1'b1;
         if (unf_ev) underflow <= 1'b1;
         if (ovf_ev && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_bus_src_fifo.sv
// tb_bus_src_fifo: scenario tasks against a queue scoreboard.
// Each task checks its own expectations inline.
module tb_bus_src_fifo;
   import bus_pkg::*;

   localparam int DEPTH = 8;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        push = 1'b0;
   logic [15:0] D_push = '0;
   logic        pop = 1'b0;
   logic        clr_flags = 1'b0;
   logic [15:0] D_pop;
   logic        pndng;
   logic        full;
   logic [3:0]  count;
   logic        overflow;
   logic        underflow;
   logic [7:0]  drop_cnt;

   int checks = 0;
   int failures = 0;

   logic [15:0] sb [$];
   logic        m_ovf = 1'b0;
   logic        m_unf = 1'b0;
   int          m_drop = 0;

   bus_src_fifo #(.pckg_sz(16), .depth(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .push(push), .D_push(D_push),
      .pop(pop), .D_pop(D_pop),
      .pndng(pndng), .full(full), .count(count),
      .overflow(overflow), .underflow(underflow),
      .drop_cnt(drop_cnt), .clr_flags(clr_flags)
   );

   always #5 clock = ~clock;

   // one clock of stimulus; scoreboard follows the intended behaviour
   task automatic step(input logic p, input logic [15:0] d,
                       input logic q, input logic c);
      int n;
      logic dq, dp, oe, ue;
      n  = sb.size();
      dq = q && (n > 0);
      dp = p && ((n < DEPTH) || dq);
      oe = p && (n == DEPTH) && !q;
      ue = q && (n == 0);
      push = p; D_push = d; pop = q; clr_flags = c;
      @(posedge clock);
      if (dq) void'(sb.pop_front());
      if (dp) sb.push_back(d);
      if (c) begin
         m_ovf = oe; m_unf = ue; m_drop = oe ? 1 : 0;
      end else begin
         if (oe) m_ovf = 1'b1;
         if (ue) m_unf = 1'b1;
         if (oe && m_drop != 255) m_drop++;
      end
      #1;
      push = 0; pop = 0; clr_flags = 0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checks++; if (pndng !== 1'b0) begin failures++; $display("FAIL rst_pndng got=%b exp=0", pndng); end
      checks++; if (full !== 1'b0) begin failures++; $display("FAIL rst_full got=%b exp=0", full); end
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
      checks++; if (D_pop !== 16'h0) begin failures++; $display("FAIL rst_dpop got=%h exp=0000", D_pop); end
      checks++; if ({overflow, underflow, drop_cnt} !== 10'd0) begin failures++; $display("FAIL rst_flags got=%b%b/%0d exp=00/0", overflow, underflow, drop_cnt); end
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_first_word();
      step(1, 16'hA001, 0, 0);
      checks++; if (pndng !== 1'b1) begin failures++; $display("FAIL fw_pndng got=%b exp=1", pndng); end
      checks++; if (D_pop !== 16'hA001) begin failures++; $display("FAIL fw_dpop got=%h exp=a001", D_pop); end
      checks++; if (count !== 4'd1) begin failures++; $display("FAIL fw_count got=%0d exp=1", count); end
      checks++; if (pkt_id(D_pop) !== 8'hA0) begin failures++; $display("FAIL fw_id got=%h exp=a0", pkt_id(D_pop)); end
      step(0, 16'h0, 1, 0);
      checks++; if (pndng !== 1'b0) begin failures++; $display("FAIL fw_drain got=%b exp=0", pndng); end
   endtask

   task automatic test_fill_overflow();
      for (int i = 1; i <= DEPTH; i++) step(1, 16'(i), 0, 0);
      checks++; if (full !== 1'b1) begin failures++; $display("FAIL fo_full got=%b exp=1", full); end
      checks++; if (count !== 4'd8) begin failures++; $display("FAIL fo_count got=%0d exp=8", count); end
      step(1, 16'h00FF, 0, 0);
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL fo_ovf got=%b exp=1", overflow); end
      checks++; if (drop_cnt !== 8'd1) begin failures++; $display("FAIL fo_drop got=%0d exp=1", drop_cnt); end
      checks++; if (count !== 4'd8) begin failures++; $display("FAIL fo_count2 got=%0d exp=8", count); end
      for (int i = 1; i <= DEPTH; i++) begin
         checks++; if (D_pop !== sb[0] || D_pop !== 16'(i)) begin failures++; $display("FAIL fo_pop%0d got=%h exp=%h", i, D_pop, 16'(i)); end
         step(0, 16'h0, 1, 0);
      end
      checks++; if (pndng !== 1'b0) begin failures++; $display("FAIL fo_empty got=%b exp=0", pndng); end
      checks++; if (D_pop !== 16'h0) begin failures++; $display("FAIL fo_dpop0 got=%h exp=0000", D_pop); end
   endtask

   task automatic test_full_push_pop();
      step(0, 16'h0, 0, 1);
      checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin failures++; $display("FAIL fp_clr got=%b/%0d exp=0/0", overflow, drop_cnt); end
      for (int i = 1; i <= DEPTH; i++) step(1, 16'h0010 + 16'(i), 0, 0);
      step(1, 16'h0B0B, 1, 0);
      checks++; if (count !== 4'd8) begin failures++; $display("FAIL fp_count got=%0d exp=8", count); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fp_ovf got=%b exp=0", overflow); end
      for (int i = 1; i <= DEPTH; i++) begin
         checks++; if (D_pop !== sb[0]) begin failures++; $display("FAIL fp_pop%0d got=%h exp=%h", i, D_pop, sb[0]); end
         if (i == DEPTH) begin
            checks++; if (D_pop !== 16'h0B0B) begin failures++; $display("FAIL fp_last got=%h exp=0b0b", D_pop); end
         end
         step(0, 16'h0, 1, 0);
      end
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL fp_drain got=%0d exp=0", count); end
   endtask

   task automatic test_underflow();
      step(0, 16'h0, 1, 0);
      checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL uf_flag got=%b exp=1", underflow); end
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL uf_count got=%0d exp=0", count); end
      step(1, 16'hC0DE, 1, 0);
      checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL uf_sticky got=%b exp=1", underflow); end
      checks++; if (count !== 4'd1) begin failures++; $display("FAIL uf_count1 got=%0d exp=1", count); end
      checks++; if (D_pop !== 16'hC0DE) begin failures++; $display("FAIL uf_dpop got=%h exp=c0de", D_pop); end
      step(0, 16'h0, 1, 1);
      checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL uf_clr got=%b exp=0", underflow); end
   endtask

   task automatic test_drop_saturate();
      for (int i = 0; i < DEPTH; i++) step(1, {BCAST_ID, 8'(i)}, 0, 0);
      for (int i = 0; i < 260; i++) step(1, 16'hDEAD, 0, 0);
      checks++; if (drop_cnt !== 8'd255) begin failures++; $display("FAIL ds_sat got=%0d exp=255", drop_cnt); end
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ds_ovf got=%b exp=1", overflow); end
      step(0, 16'h0, 0, 1);
      checks++; if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin failures++; $display("FAIL ds_clr got=%0d/%b exp=0/0", drop_cnt, overflow); end
      step(1, 16'hDEAD, 0, 1);
      checks++; if (drop_cnt !== 8'd1 || overflow !== 1'b1) begin failures++; $display("FAIL ds_prio got=%0d/%b exp=1/1", drop_cnt, overflow); end
      step(0, 16'h0, 0, 1);
      for (int i = 0; i < DEPTH; i++) begin
         checks++; if (D_pop !== {BCAST_ID, 8'(i)}) begin failures++; $display("FAIL ds_pop%0d got=%h exp=%h", i, D_pop, {BCAST_ID, 8'(i)}); end
         step(0, 16'h0, 1, 0);
      end
   endtask

   task automatic test_async_reset();
      step(0, 16'h0, 1, 0);
      for (int i = 0; i < 5; i++) step(1, 16'h5500 + 16'(i), 0, 0);
      #2;
      reset = 1'b0;
      #1;
      checks++; if (pndng !== 1'b0 || count !== 4'd0) begin failures++; $display("FAIL ar_state got=%b/%0d exp=0/0", pndng, count); end
      checks++; if (underflow !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL ar_flags got=%b/%b exp=0/0", underflow, overflow); end
      checks++; if (D_pop !== 16'h0) begin failures++; $display("FAIL ar_dpop got=%h exp=0000", D_pop); end
      @(negedge clock);
      reset = 1'b1;
      sb.delete();
      m_ovf = 0; m_unf = 0; m_drop = 0;
      step(1, 16'h1234, 0, 0);
      checks++; if (D_pop !== 16'h1234 || count !== 4'd1) begin failures++; $display("FAIL ar_push got=%h/%0d exp=1234/1", D_pop, count); end
      step(0, 16'h0, 1, 0);
   endtask

   task automatic test_random();
      logic p, q, c;
      int bias;
      for (int i = 0; i < 400; i++) begin
         bias = (i / 50) % 2 == 0 ? 75 : 25;
         checks++; if (count !== 4'(sb.size())) begin failures++; $display("FAIL rnd_count%0d got=%0d exp=%0d", i, count, sb.size()); end
         checks++; if (full !== (sb.size() == DEPTH) || pndng !== (sb.size() != 0)) begin failures++; $display("FAIL rnd_stat%0d got=%b%b", i, full, pndng); end
         checks++; if (D_pop !== (sb.size() != 0 ? sb[0] : 16'h0)) begin failures++; $display("FAIL rnd_dpop%0d got=%h", i, D_pop); end
         checks++; if ({overflow, underflow} !== {m_ovf, m_unf} || int'(drop_cnt) != m_drop) begin failures++; $display("FAIL rnd_flags%0d got=%b%b/%0d exp=%b%b/%0d", i, overflow, underflow, drop_cnt, m_ovf, m_unf, m_drop); end
         p = ($urandom_range(0, 99) < bias);
         q = ($urandom_range(0, 99) >= bias);
         c = ($urandom_range(0, 19) == 0);
         step(p, 16'($urandom), q, c);
      end
   endtask

   initial begin
      test_reset();
      test_first_word();
      test_fill_overflow();
      test_full_push_pop();
      test_underflow();
      test_drop_saturate();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
